ft232r_tx_arb: RTL and testbench

Round-robin packet arbiter that shares the single FT232R UART transmit port (wr_req/wr_ack/wr_data) between NREQ byte-stream requesters. A grant is held for a whole packet, delimited by req_last, so bytes from different requesters never interleave on the wire. Each packet can optionally be prefixed with a channel-ID header byte. The block sits between on-chip data sources and the ft232r_hs write interface.

---
 rtl/ft232r_tx_arb_if.sv | 25 ++
 rtl/ft232r_tx_arb.sv | 159 +++++++++++++++
 tb/tb_ft232r_tx_arb.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ft232r_tx_arb_if.sv
// Requester and UART-side signals of the FT232R transmit arbiter, bundled for port connection.
interface ft232r_tx_arb_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ack;
  logic              wr_req;
  logic [7:0]        wr_data;
  logic              wr_ack;
  logic              busy;
  logic [2:0]        grant_id;
  logic              stall_err;

  modport slave (
    input  req_valid, req_data, req_last, wr_ack,
    output req_ack, wr_req, wr_data, busy, grant_id, stall_err
  );

  modport master (
    output req_valid, req_data, req_last, wr_ack,
    input  req_ack, wr_req, wr_data, busy, grant_id, stall_err
  );
endinterface

// File: rtl/ft232r_tx_arb.sv
// Round-robin packet arbiter sharing one FT232R write port; a grant spans a whole packet,
// optionally prefixed with a channel-ID header byte.
module ft232r_tx_arb #(
  parameter int         NREQ      = 4,
  parameter bit         HDR_EN    = 1'b1,
  parameter logic [7:0] HDR_BASE  = 8'hA0,
  parameter int         STALL_MAX = 1023
) (
  input logic            clk,
  input logic            rst,
  ft232r_tx_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, GAP} state_t;

  state_t          state_q, state_d;
  state_t          target_q, target_d;
  logic            wr_req_q, wr_req_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic [NREQ-1:0] req_ack_q, req_ack_d;
  logic            busy_q, busy_d;
  logic [2:0]      grant_q, grant_d;
  logic [2:0]      last_q, last_d;
  logic            stall_err_q, stall_err_d;
  logic [15:0]     stall_q, stall_d;

  // Zero-padded views let a 3-bit index address any NREQ without width games.
  logic [7:0]  valid_pad;
  logic [7:0]  last_pad;
  logic [63:0] data_pad;
  assign valid_pad = 8'(bus.req_valid);
  assign last_pad  = 8'(bus.req_last);
  assign data_pad  = 64'(bus.req_data);

  logic       found;
  logic [2:0] pick;
  logic [3:0] cand;

  always_comb begin : rr_search
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, last_q} + 4'(i);
      if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
      if (!found && valid_pad[cand[2:0]]) begin
        found = 1'b1;
        pick  = cand[2:0];
      end
    end
  end

  logic [15:0] stall_inc;

  always_comb begin : next_state
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_d     = state_q;
    target_d    = target_q;
    wr_req_d    = wr_req_q;
    wr_data_d   = wr_data_q;
    req_ack_d   = '0;
    grant_d     = grant_q;
    last_d      = last_q;
    stall_err_d = 1'b0;
    stall_d     = stall_q;
    stall_inc   = stall_q + 16'd1;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d  = pick;
          stall_d  = '0;
          wr_req_d = 1'b1;
          if (HDR_EN) begin
            state_d   = HDR;
            wr_data_d = HDR_BASE + {5'b0, pick};
          end else begin
            state_d   = DATA;
            wr_data_d = data_pad[{pick, 3'b000} +: 8];
          end
        end
      end
      HDR: begin
        if (bus.wr_ack) begin
          wr_req_d = 1'b0;
          target_d = DATA;
          state_d  = GAP;
        end
      end
      DATA: begin
        if (!wr_req_q) begin
          if (valid_pad[grant_q]) begin
            wr_req_d  = 1'b1;
            wr_data_d = data_pad[{grant_q, 3'b000} +: 8];
            stall_d   = '0;
          end else if (STALL_MAX != 0 && stall_inc == 16'(STALL_MAX)) begin
            stall_err_d = 1'b1;
            last_d      = grant_q;
            stall_d     = '0;
            state_d     = IDLE;
          end else begin
            stall_d = stall_inc;
          end
        end else if (bus.wr_ack) begin
          wr_req_d = 1'b0;
          for (int i = 0; i < NREQ; i++) begin
            if (grant_q == 3'(i)) req_ack_d[i] = 1'b1;
          end
          if (last_pad[grant_q]) begin
            target_d = IDLE;
            last_d   = grant_q;
          end else begin
            target_d = DATA;
          end
          state_d = GAP;
        end
      end
      GAP: state_d = target_q;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      target_q    <= IDLE;
      wr_req_q    <= 1'b0;
      wr_data_q   <= '0;
      req_ack_q   <= '0;
      busy_q      <= 1'b0;
      grant_q     <= '0;
      last_q      <= 3'(NREQ - 1);
      stall_err_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      wr_req_q    <= wr_req_d;
      wr_data_q   <= wr_data_d;
      req_ack_q   <= req_ack_d;
      busy_q      <= busy_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      stall_err_q <= stall_err_d;
      stall_q     <= stall_d;
    end
  end

  assign bus.wr_req    = wr_req_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.req_ack   = req_ack_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = grant_q;
  assign bus.stall_err = stall_err_q;

endmodule

// File: tb/tb_ft232r_tx_arb.sv
// Bench for ft232r_tx_arb: a header-enabled instance with a short stall limit driven by
// requester/UART models plus a byte scoreboard, and a header-less instance driven by hand.
module tb_ft232r_tx_arb;
  localparam int NREQ    = 4;
  localparam int ACK_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ft232r_tx_arb_if #(.NREQ(NREQ)) ifa ();
  ft232r_tx_arb_if #(.NREQ(NREQ)) ifb ();

  ft232r_tx_arb #(.NREQ(NREQ), .HDR_EN(1'b1), .HDR_BASE(8'hA0), .STALL_MAX(4))
    u_a (.clk(clk), .rst(rst), .bus(ifa));
  ft232r_tx_arb #(.NREQ(NREQ), .HDR_EN(1'b0), .HDR_BASE(8'hA0), .STALL_MAX(0))
    u_b (.clk(clk), .rst(rst), .bus(ifb));

  int tests = 0;
  int fails = 0;

  logic [8:0]      rq [NREQ][$];   // {last, data} per requester of instance a
  logic [7:0]      sb [$];         // expected bytes on instance a's wr_data
  logic [NREQ-1:0] en = '0;
  int              ack_cnt [NREQ];
  int              stall_cnt = 0;
  int              ua_cnt = 0;
  int              ua_hold = 0;

  typedef struct {
    logic [3:0] mask;
    logic [2:0] exp_grant;
  } vec_t;
  vec_t vt [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input logic [7:0] d);
    logic [7:0] e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL sb_extra: got 0x%0h, required no byte", d);
    end else begin
      e = sb.pop_front();
      check("sb_byte", 32'(d), 32'(e));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input logic last);
    rq[r].push_back({last, d});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = '0;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    sb.delete();
    ifb.req_valid = '0;
    ifb.req_last  = '0;
    ifb.req_data  = '0;
    ifb.wr_ack    = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) ack_cnt[i] = 0;
    stall_cnt = 0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c;
    bit pend;
    c    = 0;
    pend = 1'b1;
    while (pend && c < budget) begin
      step();
      c++;
      pend = (sb.size() != 0) || ifa.busy;
      for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) pend = 1'b1;
    end
    check({name, "_done"}, 32'(pend), 32'd0);
  endtask

  // Requester model for instance a: pops on req_ack, presents the next queued byte.
  initial begin : drv_a
    ifa.req_valid = '0;
    ifa.req_last  = '0;
    ifa.req_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (ifa.req_ack[i]) begin
          ack_cnt[i]++;
          if (rq[i].size() != 0) void'(rq[i].pop_front());
        end
        if (en[i] && rq[i].size() != 0) begin
          ifa.req_valid[i]        = 1'b1;
          ifa.req_data[8*i +: 8]  = rq[i][0][7:0];
          ifa.req_last[i]         = rq[i][0][8];
        end else begin
          ifa.req_valid[i]        = 1'b0;
          ifa.req_data[8*i +: 8]  = 8'h00;
          ifa.req_last[i]         = 1'b0;
        end
      end
      if (ifa.stall_err) stall_cnt++;
    end
  end

  // UART model for instance a: acks ACK_LAT cycles after wr_req and scores the byte.
  initial begin : uart_a
    ifa.wr_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        ifa.wr_ack = 1'b0;
        ua_cnt     = 0;
        ua_hold    = 0;
      end else if (ifa.wr_ack) begin
        ua_hold--;
        if (ua_hold <= 0) ifa.wr_ack = 1'b0;
      end else if (ifa.wr_req) begin
        ua_cnt++;
        if (ua_cnt == ACK_LAT) begin
          ua_cnt     = 0;
          ua_hold    = 1;
          ifa.wr_ack = 1'b1;
          sb_check(ifa.wr_data);
        end
      end else begin
        ua_cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int acks;
    int rises;
    int k;
    logic prev;

    vt[0] = '{4'b1111, 3'd0};
    vt[1] = '{4'b1111, 3'd1};
    vt[2] = '{4'b1001, 3'd3};
    vt[3] = '{4'b0110, 3'd1};
    vt[4] = '{4'b0001, 3'd0};
    vt[5] = '{4'b0001, 3'd0};
    vt[6] = '{4'b1100, 3'd2};
    vt[7] = '{4'b0100, 3'd2};

    ifb.req_valid = '0;
    ifb.req_last  = '0;
    ifb.req_data  = '0;
    ifb.wr_ack    = 1'b0;
    do_reset();

    check("rst_a_wr_req",  32'(ifa.wr_req),    32'd0);
    check("rst_a_wr_data", 32'(ifa.wr_data),   32'd0);
    check("rst_a_req_ack", 32'(ifa.req_ack),   32'd0);
    check("rst_a_busy",    32'(ifa.busy),      32'd0);
    check("rst_a_grant",   32'(ifa.grant_id),  32'd0);
    check("rst_a_stall",   32'(ifa.stall_err), 32'd0);
    check("rst_b_wr_req",  32'(ifb.wr_req),    32'd0);
    check("rst_b_busy",    32'(ifb.busy),      32'd0);

    // Header-less instance: one-byte packets, round-robin priority table.
    for (int v = 0; v < 8; v++) begin
      logic [7:0] eb;
      logic [3:0] em;
      eb = {4'(v), 1'b0, vt[v].exp_grant};
      em = 4'(1) << vt[v].exp_grant;
      ifb.req_valid = vt[v].mask;
      ifb.req_last  = '1;
      for (int i = 0; i < NREQ; i++) ifb.req_data[8*i +: 8] = {4'(v), 4'(i)};
      step();
      check($sformatf("vec%0d_wr_req", v),  32'(ifb.wr_req),   32'd1);
      check($sformatf("vec%0d_grant", v),   32'(ifb.grant_id), 32'(vt[v].exp_grant));
      check($sformatf("vec%0d_wr_data", v), 32'(ifb.wr_data),  32'(eb));
      check($sformatf("vec%0d_busy", v),    32'(ifb.busy),     32'd1);
      ifb.wr_ack = 1'b1;
      step();
      check($sformatf("vec%0d_wr_req_off", v), 32'(ifb.wr_req),  32'd0);
      check($sformatf("vec%0d_req_ack", v),    32'(ifb.req_ack), 32'(em));
      ifb.wr_ack    = 1'b0;
      ifb.req_valid = '0;
      step();
      check($sformatf("vec%0d_ack_clear", v), 32'(ifb.req_ack), 32'd0);
      check($sformatf("vec%0d_idle", v),      32'(ifb.busy),    32'd0);
    end

    // One-byte packet 0xb1 with wr_ack held for five cycles.
    ifb.req_valid        = 4'b0001;
    ifb.req_last         = '1;
    ifb.req_data[7:0]    = 8'hb1;
    step();
    check("b1_wr_req",  32'(ifb.wr_req),   32'd1);
    check("b1_wr_data", 32'(ifb.wr_data),  32'hb1);
    check("b1_grant",   32'(ifb.grant_id), 32'd0);
    ifb.wr_ack = 1'b1;
    acks  = 0;
    rises = 0;
    prev  = 1'b1;
    for (int j = 0; j < 8; j++) begin
      step();
      if (ifb.req_ack[0]) begin
        acks++;
        ifb.req_valid = '0;
      end
      if (ifb.wr_req && !prev) rises++;
      prev = ifb.wr_req;
      if (j == 4) ifb.wr_ack = 1'b0;
    end
    check("long_ack_req_acks", 32'(acks),         32'd1);
    check("long_ack_rerequest", 32'(rises),       32'd0);
    check("long_ack_wr_data",  32'(ifb.wr_data),  32'hb1);
    check("long_ack_busy",     32'(ifb.busy),     32'd0);

    // Reset while a byte is in flight and acked on the same edge.
    ifb.req_valid         = 4'b0100;
    ifb.req_data[23:16]   = 8'h5a;
    step();
    check("mid_wr_req", 32'(ifb.wr_req),   32'd1);
    check("mid_grant",  32'(ifb.grant_id), 32'd2);
    rst        = 1'b1;
    ifb.wr_ack = 1'b1;
    step();
    check("mid_rst_wr_req",  32'(ifb.wr_req),    32'd0);
    check("mid_rst_wr_data", 32'(ifb.wr_data),   32'd0);
    check("mid_rst_req_ack", 32'(ifb.req_ack),   32'd0);
    check("mid_rst_busy",    32'(ifb.busy),      32'd0);
    check("mid_rst_grant",   32'(ifb.grant_id),  32'd0);
    check("mid_rst_stall",   32'(ifb.stall_err), 32'd0);
    rst                 = 1'b0;
    ifb.wr_ack          = 1'b0;
    ifb.req_valid       = 4'b0110;
    ifb.req_data[15:8]  = 8'h6b;
    step();
    check("post_rst_grant",   32'(ifb.grant_id), 32'd1);
    check("post_rst_wr_data", 32'(ifb.wr_data),  32'h6b);
    check("post_rst_req_ack", 32'(ifb.req_ack),  32'd0);

    // Single requester with header.
    do_reset();
    sb.push_back(8'hA0); sb.push_back(8'h5c); sb.push_back(8'hae);
    push_byte(0, 8'h5c, 1'b0);
    push_byte(0, 8'hae, 1'b1);
    en = 4'b0001;
    wait_done("single", 200);
    check("single_acks",  32'(ack_cnt[0]), 32'd2);
    check("single_busy",  32'(ifa.busy),   32'd0);
    check("single_stall", 32'(stall_cnt),  32'd0);

    // Contention after reset: two rounds of 0, 1, 3.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (i != 2) begin
          sb.push_back(8'hA0 + 8'(i));
          for (int b = 0; b < 2; b++) begin
            sb.push_back(8'h80 + 8'(16 * i + 2 * r + b));
            push_byte(i, 8'h80 + 8'(16 * i + 2 * r + b), b == 1);
          end
        end
      end
    end
    en = 4'b1011;
    wait_done("contend", 600);
    check("contend_acks0", 32'(ack_cnt[0]), 32'd4);
    check("contend_acks1", 32'(ack_cnt[1]), 32'd4);
    check("contend_acks3", 32'(ack_cnt[3]), 32'd4);
    check("contend_stall", 32'(stall_cnt),  32'd0);

    // Fairness: requester 2 streams, requester 1 joins once 2 holds the grant.
    do_reset();
    sb.push_back(8'hA2); sb.push_back(8'h2a); sb.push_back(8'h2b);
    sb.push_back(8'hA1); sb.push_back(8'h1a); sb.push_back(8'h1b);
    sb.push_back(8'hA2); sb.push_back(8'h2c); sb.push_back(8'h2d);
    push_byte(2, 8'h2a, 1'b0); push_byte(2, 8'h2b, 1'b1);
    push_byte(2, 8'h2c, 1'b0); push_byte(2, 8'h2d, 1'b1);
    push_byte(1, 8'h1a, 1'b0); push_byte(1, 8'h1b, 1'b1);
    en = 4'b0100;
    k  = 0;
    while (!ifa.busy && k < 20) begin
      step();
      k++;
    end
    check("fair_first_grant", 32'(ifa.grant_id), 32'd2);
    en = 4'b0110;
    wait_done("fair", 400);
    check("fair_stall", 32'(stall_cnt), 32'd0);

    // Stall: one byte without last, then the requester goes quiet.
    do_reset();
    sb.push_back(8'hA0); sb.push_back(8'h40);
    push_byte(0, 8'h40, 1'b0);
    en = 4'b0001;
    k  = 0;
    while (!ifa.req_ack[0] && k < 40) begin
      step();
      k++;
    end
    check("stall_data_acked", 32'(ifa.req_ack[0]), 32'd1);
    k = 0;
    while (!ifa.stall_err && k < 12) begin
      step();
      k++;
    end
    check("stall_delay", 32'(k),           32'd5);
    check("stall_busy",  32'(ifa.busy),    32'd0);
    sb.push_back(8'hA1); sb.push_back(8'h51);
    sb.push_back(8'hA3); sb.push_back(8'h53);
    push_byte(1, 8'h51, 1'b1);
    push_byte(3, 8'h53, 1'b1);
    en = 4'b1011;
    wait_done("after_stall", 300);
    check("stall_pulses", 32'(stall_cnt), 32'd1);
    check("stall_acks0",  32'(ack_cnt[0]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
